fp_normalize_stage: RTL and testbench

//  FPU add/sub normalize stage, directly downstream of the leading-one shift counter.

---
 rtl/fp_normalize_stage_pkg.sv | 32 +++
 rtl/fp_normalize_stage_shl.sv | 22 ++
 rtl/fp_normalize_stage.sv | 117 +++++++++++
 tb/tb_fp_normalize_stage.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/fp_normalize_stage_pkg.sv
// Shared FPU single-precision constants, stage-1 payload and result classification.
package fp_normalize_stage_pkg;

  localparam int FP_EXP_W   = 8;
  localparam int FP_MANT_W  = 24;
  localparam int FP_SHAMT_W = 5;
  localparam int FP_FRAC_W  = FP_MANT_W - 1;
  localparam int FP_EADJ_W  = FP_EXP_W + 2;
  localparam logic [FP_EXP_W-1:0] FP_EXP_MAX = 8'hFF;

  typedef struct packed {
    logic                 sign;
    logic                 zero;
    logic [FP_EADJ_W-1:0] e;     // two's complement adjusted exponent
    logic [FP_MANT_W-1:0] m;
  } s1_t;

  typedef enum logic [1:0] {
    CLS_NORM = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_UNF  = 2'd2,
    CLS_OVF  = 2'd3
  } cls_e;

  function automatic cls_e classify(input logic z, input logic [FP_EADJ_W-1:0] e);
    if (z)                                      return CLS_ZERO;
    else if ($signed(e) <= 0)                   return CLS_UNF;
    else if ($signed(e) >= int'(FP_EXP_MAX))    return CLS_OVF;
    else                                        return CLS_NORM;
  endfunction

endpackage

// File: rtl/fp_normalize_stage_shl.sv
// Logarithmic left barrel shifter: one 2:1 mux rank per shift-amount bit.
module mant_shl_barrel #(
  parameter int W  = 24,
  parameter int SW = 5
) (
  input  logic [W-1:0]  d_i,
  input  logic [SW-1:0] sh_i,
  output logic [W-1:0]  q_o
);

  logic [SW:0][W-1:0] stg;

  assign stg[0] = d_i;

  for (genvar k = 0; k < SW; k++) begin : g_stg
    localparam int SH = 2 ** k;
    assign stg[k+1] = sh_i[k] ? (stg[k] << SH) : stg[k];
  end

  assign q_o = stg[SW];

endmodule

// File: rtl/fp_normalize_stage.sv
// FPU add/sub normalize stage: shift/adjust (S1), classify/pack (S2), valid/ready pipelined.
module fp_normalize_stage
  import fp_normalize_stage_pkg::*;
#(
  parameter int EXP_W   = FP_EXP_W,
  parameter int MANT_W  = FP_MANT_W,
  parameter int SHAMT_W = FP_SHAMT_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 sign_in,
  input  logic [EXP_W-1:0]     exp_in,
  input  logic                 cOut,
  input  logic [MANT_W-1:0]    Mcps,
  input  logic                 LRbar,
  input  logic [SHAMT_W-1:0]   numBits,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [EXP_W+MANT_W:0] result,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 zero
);

  localparam int EW = EXP_W + 2;

  logic                  s1_v_q, s2_v_q;
  logic                  s1_adv, s2_adv;
  s1_t                   s1_q, s1_d;
  logic [MANT_W-1:0]     shl_m;
  logic [EXP_W+MANT_W:0] res_q, res_d;
  logic                  ovf_q, ovf_d, unf_q, unf_d, zero_q, zero_d;
  cls_e                  cls;
  logic                  unused_msb;

  // Ready depends only on pipe occupancy and downstream ready, never on in_valid.
  assign s2_adv   = ~s2_v_q | out_ready;
  assign s1_adv   = ~s1_v_q | s2_adv;
  assign in_ready = s1_adv;

  mant_shl_barrel #(.W(MANT_W), .SW(SHAMT_W)) u_shl (
    .d_i  (Mcps),
    .sh_i (numBits),
    .q_o  (shl_m)
  );

  always_comb begin
    s1_d      = '0;
    s1_d.sign = sign_in;
    s1_d.zero = ~cOut & ~|Mcps;
    if (LRbar) begin
      s1_d.m = shl_m;
      s1_d.e = {2'b00, exp_in} - {{(EW-SHAMT_W){1'b0}}, numBits};
    end else begin
      // Right shift by one absorbs the carry; Mcps[0] is dropped (truncation).
      s1_d.m = {cOut, Mcps[MANT_W-1:1]};
      s1_d.e = {2'b00, exp_in} + {{(EW-1){1'b0}}, 1'b1};
    end
  end

  assign cls        = classify(s1_q.zero, s1_q.e);
  assign unused_msb = s1_q.m[MANT_W-1];

  always_comb begin
    res_d  = '0;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    zero_d = 1'b0;
    unique case (cls)
      CLS_ZERO: zero_d = 1'b1;
      CLS_UNF: begin
        res_d = {s1_q.sign, {(EXP_W+MANT_W-1){1'b0}}};
        unf_d = 1'b1;
      end
      CLS_OVF: begin
        res_d = {s1_q.sign, FP_EXP_MAX, {(MANT_W-1){1'b0}}};
        ovf_d = 1'b1;
      end
      default: res_d = {s1_q.sign, s1_q.e[EXP_W-1:0], s1_q.m[MANT_W-2:0]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
      s1_q   <= '0;
      res_q  <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_v_q <= in_valid;
        if (in_valid) s1_q <= s1_d;
      end
      if (s2_adv) begin
        s2_v_q <= s1_v_q;
        if (s1_v_q) begin
          res_q  <= res_d;
          ovf_q  <= ovf_d;
          unf_q  <= unf_d;
          zero_q <= zero_d;
        end
      end
    end
  end

  assign out_valid = s2_v_q;
  assign result    = res_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_fp_normalize_stage.sv
// Directed vectors, backpressure, random streaming against an arithmetic model, and mid-flight reset.
module tb_fp_normalize_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic        sign_in;
  logic [7:0]  exp_in;
  logic        cOut;
  logic [23:0] Mcps;
  logic        LRbar;
  logic [4:0]  numBits;
  logic        out_valid, out_ready;
  logic [31:0] result;
  logic        overflow, underflow, zero;
  logic [34:0] obs;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  logic [34:0] q[$];
  bit          hold_v = 1'b0;
  logic [35:0] hold_val;

  always #5 clk = ~clk;

  assign obs = {result, overflow, underflow, zero};

  fp_normalize_stage dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .sign_in(sign_in), .exp_in(exp_in), .cOut(cOut), .Mcps(Mcps),
    .LRbar(LRbar), .numBits(numBits), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .overflow(overflow), .underflow(underflow), .zero(zero)
  );

  // Value-level model: {result, overflow, underflow, zero}.
  function automatic logic [34:0] model(input logic s, input logic [7:0] ex, input logic co,
                                        input logic [23:0] mc, input logic lr, input logic [4:0] nb);
    longint mant;
    int     e;
    if (!co && mc == 0) return {32'h0, 3'b001};
    if (!lr) begin
      mant = (longint'(co) * (64'd1 << 24) + longint'(mc)) / 2;
      e    = int'(ex) + 1;
    end else begin
      mant = (longint'(mc) * (64'd1 << nb)) % (64'd1 << 24);
      e    = int'(ex) - int'(nb);
    end
    if (e <= 0)   return {s, 31'b0, 3'b010};
    if (e >= 255) return {s, 8'hFF, 23'b0, 3'b100};
    return {s, 8'(e), 23'(mant % (64'd1 << 23)), 3'b000};
  endfunction

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic gen();
    int r;
    logic [23:0] t;
    logic [4:0]  nb;
    r       = $urandom_range(0, 9);
    sign_in = 1'($urandom);
    exp_in  = 8'($urandom_range(0, 255));
    if (r == 0) begin
      cOut = 1'b0; Mcps = 24'h0; LRbar = 1'($urandom); numBits = 5'($urandom);
    end else if (r < 4) begin
      cOut = 1'b1; Mcps = 24'($urandom); LRbar = 1'b0; numBits = 5'($urandom);
    end else begin
      nb      = 5'($urandom_range(0, 23));
      t       = 24'($urandom) | 24'h800000;
      cOut    = 1'b0; LRbar = 1'b1;
      Mcps    = t >> nb;
      numBits = nb;
    end
  endtask

  // Called just after a negedge: records the transfers of the coming posedge, then advances.
  task automatic tick(output bit acc);
    #1;
    acc = in_valid && in_ready;
    if (acc) q.push_back(model(sign_in, exp_in, cOut, Mcps, LRbar, numBits));
    if (hold_v) chk("stall_hold", {4'b0, out_valid, obs}, {4'b0, hold_val});
    if (out_valid && out_ready) begin
      if (q.size() == 0) chk("spurious_out", {39'b0, out_valid}, 40'd0);
      else begin
        chk("stream", {5'b0, obs}, {5'b0, q.pop_front()});
        n_out++;
      end
    end
    hold_v   = out_valid && !out_ready;
    hold_val = {out_valid, obs};
    @(negedge clk);
  endtask

  task automatic directed(input string tag, input logic s, input logic [7:0] ex, input logic co,
                          input logic [23:0] mc, input logic lr, input logic [4:0] nb,
                          input logic [34:0] exp);
    sign_in = s; exp_in = ex; cOut = co; Mcps = mc; LRbar = lr; numBits = nb;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk({tag, "_lat1"}, {39'b0, out_valid}, 40'd0);
    @(negedge clk);
    #1 chk({tag, "_valid"}, {39'b0, out_valid}, 40'd1);
    chk(tag, {5'b0, obs}, {5'b0, exp});
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bit acc;
    int n_sent;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    sign_in = 1'b0; exp_in = '0; cOut = 1'b0; Mcps = '0; LRbar = 1'b0; numBits = '0;
    @(negedge clk);
    @(negedge clk);
    #1 chk("reset_state", {3'b0, in_ready, out_valid, obs}, {3'b0, 1'b1, 1'b0, 35'h0});
    reset = 1'b0;
    @(negedge clk);

    directed("right_shift", 1'b0, 8'd127, 1'b1, 24'h800000, 1'b0, 5'd0, {32'h40400000, 3'b000});
    directed("left_shift",  1'b0, 8'd127, 1'b0, 24'h400000, 1'b1, 5'd1, {32'h3F000000, 3'b000});
    directed("zero",        1'b1, 8'd127, 1'b0, 24'h000000, 1'b1, 5'd0, {32'h00000000, 3'b001});
    directed("overflow",    1'b1, 8'd254, 1'b1, 24'h000000, 1'b0, 5'd0, {32'hFF800000, 3'b100});
    directed("underflow",   1'b1, 8'd3,   1'b0, 24'h040000, 1'b1, 5'd5, {32'h80000000, 3'b010});
    directed("exp_max_in",  1'b0, 8'd255, 1'b0, 24'h800000, 1'b1, 5'd1, {32'h7F000000, 3'b000});

    // Backpressure: 4 back-to-back inputs, downstream stalled for 3 cycles.
    n_sent = 0; n_out = 0;
    gen();
    for (int cyc = 0; cyc < 40 && (n_sent < 4 || q.size() > 0); cyc++) begin
      out_ready = (cyc >= 3);
      in_valid  = (n_sent < 4);
      if (cyc == 2) begin
        #1 chk("bp_in_ready", {39'b0, in_ready}, 40'd0);
        chk("bp_accepted", 40'(n_sent), 40'd2);
      end
      tick(acc);
      if (acc) begin n_sent++; gen(); end
    end
    in_valid = 1'b0;
    chk("bp_count", 40'(n_out), 40'd4);
    chk("bp_drain", 40'(q.size()), 40'd0);

    // Random streaming with random stalls on both sides.
    gen();
    in_valid = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      tick(acc);
      if (acc || !in_valid) begin
        gen();
        in_valid = ($urandom_range(0, 3) != 0);
      end
    end
    in_valid = 1'b0; out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && q.size() > 0; cyc++) tick(acc);
    chk("rand_drain", 40'(q.size()), 40'd0);

    // Reset with the pipe full.
    out_ready = 1'b0; in_valid = 1'b1;
    gen(); tick(acc);
    gen(); tick(acc);
    in_valid = 1'b0;
    #1 chk("full_before_reset", {38'b0, out_valid, in_ready}, 40'b10);
    reset = 1'b1;
    @(negedge clk);
    #1 chk("reset_mid_valid", {38'b0, out_valid, in_ready}, 40'b01);
    reset = 1'b0;
    q.delete();
    hold_v = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 5; cyc++) begin
      @(negedge clk);
      #1 chk("no_stale", {39'b0, out_valid}, 40'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
